peripheral_bus_responder: RTL and testbench

PERIPHERAL_BUS_RESPONDER -- requirements
Module: peripheral_bus_responder

---
 rtl/peripheral_bus_responder.sv | 179 +++++++++++++++++
 tb/tb_peripheral_bus_responder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_bus_responder.sv
// Memory-mapped peripheral block: timer with reload/IRQ, LED, switch and seven-segment registers.
// Latency: reads are combinational in the strobe cycle; writes commit at the next rising clk.
// Backpressure: none, every access completes in one cycle. Define PERIPH_SYSTICK_EN to add SYSTICK at 0x18.
module peripheral_bus_responder (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] iMemAddr,
    input  logic        iMemRead,
    input  logic        iMemWrite,
    input  logic [31:0] iMemWriteData,
    output logic [31:0] oMemReadData,
    output logic        oInterrupt,
    output logic [7:0]  oLed,
    input  logic [7:0]  iSwitch,
    output logic [11:0] oDigit
);

    // Word index (iMemAddr[7:2]) of each mapped register inside the 256-byte window
    localparam logic [5:0] WORD_TH      = 6'h00;
    localparam logic [5:0] WORD_TL      = 6'h01;
    localparam logic [5:0] WORD_TCON    = 6'h02;
    localparam logic [5:0] WORD_LED     = 6'h03;
    localparam logic [5:0] WORD_SWITCH  = 6'h04;
    localparam logic [5:0] WORD_DIGI    = 6'h05;
`ifdef PERIPH_SYSTICK_EN
    localparam logic [5:0] WORD_SYSTICK = 6'h06;
`endif

    localparam logic [23:0] BASE_PAGE = 24'h400000;
    localparam logic [31:0] TL_MAX    = 32'hFFFF_FFFF;

    // TCON bit positions
    localparam int TCON_EN     = 0;
    localparam int TCON_IRQ_EN = 1;
    localparam int TCON_IRQ    = 2;

    // Architectural state
    logic [31:0] r_th;
    logic [31:0] r_tl;
    logic [2:0]  r_tcon;
    logic [7:0]  r_led;
    logic [11:0] r_digi;
    logic [7:0]  r_sw_meta;
    logic [7:0]  r_sw_sync;
`ifdef PERIPH_SYSTICK_EN
    logic [31:0] r_systick;
`endif

    // Decode
    logic        w_hit;
    logic [5:0]  w_word;
    logic        w_wr_th;
    logic        w_wr_tl;
    logic        w_wr_tcon;
    logic        w_wr_led;
    logic        w_wr_digi;

    // Timer datapath
    logic        w_reload;
    logic        w_irq_set;
    logic [31:0] w_tl_nxt;
    logic [2:0]  w_tcon_nxt;
    logic [31:0] w_rdata;

    // Byte-lane bits are don't-care: the bus is word addressed
    logic        w_unused_addr;
    assign w_unused_addr = &{1'b0, iMemAddr[1:0]};

    assign w_hit  = (iMemAddr[31:8] == BASE_PAGE);
    assign w_word = iMemAddr[7:2];

    // SWITCH and SYSTICK have no write enable, so writes to them fall through harmlessly
    assign w_wr_th   = iMemWrite && w_hit && (w_word == WORD_TH);
    assign w_wr_tl   = iMemWrite && w_hit && (w_word == WORD_TL);
    assign w_wr_tcon = iMemWrite && w_hit && (w_word == WORD_TCON);
    assign w_wr_led  = iMemWrite && w_hit && (w_word == WORD_LED);
    assign w_wr_digi = iMemWrite && w_hit && (w_word == WORD_DIGI);

    // A reload happens on the edge where a running counter sits at all-ones
    assign w_reload  = r_tcon[TCON_EN] && (r_tl == TL_MAX);
    assign w_irq_set = w_reload && r_tcon[TCON_IRQ_EN];

    // Next-state for TL and TCON: CPU writes win over counting, but an IRQ set is never lost
    always_comb begin
        w_tl_nxt   = r_tl;
        w_tcon_nxt = r_tcon;

        if (w_wr_tl) begin
            w_tl_nxt = iMemWriteData;
        end else if (r_tcon[TCON_EN]) begin
            w_tl_nxt = w_reload ? r_th : (r_tl + 32'd1);
        end

        if (w_wr_tcon) begin
            w_tcon_nxt = iMemWriteData[2:0];
        end
        // Set beats a simultaneous clear of the status bit
        if (w_irq_set) begin
            w_tcon_nxt[TCON_IRQ] = 1'b1;
        end
    end

    // Timer and control registers; reset overrides any write or reload in the same cycle
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_th   <= '0;
            r_tl   <= '0;
            r_tcon <= '0;
        end else begin
            if (w_wr_th) begin
                r_th <= iMemWriteData;
            end
            r_tl   <= w_tl_nxt;
            r_tcon <= w_tcon_nxt;
        end
    end

    // LED and seven-segment output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_led  <= '0;
            r_digi <= '0;
        end else begin
            if (w_wr_led) begin
                r_led <= iMemWriteData[7:0];
            end
            if (w_wr_digi) begin
                r_digi <= iMemWriteData[11:0];
            end
        end
    end

    // Two-flop synchronizer for the asynchronous switch inputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sw_meta <= '0;
            r_sw_sync <= '0;
        end else begin
            r_sw_meta <= iSwitch;
            r_sw_sync <= r_sw_meta;
        end
    end

`ifdef PERIPH_SYSTICK_EN
    // Free-running tick counter, wraps naturally at 2^32
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_systick <= '0;
        end else begin
            r_systick <= r_systick + 32'd1;
        end
    end
`endif

    // Read mux: zero unless a strobed read hits a mapped register
    always_comb begin
        w_rdata = 32'h0;
        if (iMemRead && w_hit) begin
            case (w_word)
                WORD_TH:      w_rdata = r_th;
                WORD_TL:      w_rdata = r_tl;
                WORD_TCON:    w_rdata = {29'h0, r_tcon};
                WORD_LED:     w_rdata = {24'h0, r_led};
                WORD_SWITCH:  w_rdata = {24'h0, r_sw_sync};
                WORD_DIGI:    w_rdata = {20'h0, r_digi};
`ifdef PERIPH_SYSTICK_EN
                WORD_SYSTICK: w_rdata = r_systick;
`endif
                default:      w_rdata = 32'h0;
            endcase
        end
    end

    assign oMemReadData = w_rdata;
    assign oInterrupt   = r_tcon[TCON_IRQ];
    assign oLed         = r_led;
    assign oDigit       = r_digi;

endmodule

// File: tb/tb_peripheral_bus_responder.sv
// Randomized and directed bench for peripheral_bus_responder against a register-level model.
// Latency: one bus access per clock; outputs sampled 1ns after the falling edge.
// Backpressure: none; watchdog bounds total run time.
module tb_peripheral_bus_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] iMemAddr;
    logic        iMemRead;
    logic        iMemWrite;
    logic [31:0] iMemWriteData;
    logic [31:0] oMemReadData;
    logic        oInterrupt;
    logic [7:0]  oLed;
    logic [7:0]  iSwitch;
    logic [11:0] oDigit;

    peripheral_bus_responder dut (
        .clk           (clk),
        .reset         (reset),
        .iMemAddr      (iMemAddr),
        .iMemRead      (iMemRead),
        .iMemWrite     (iMemWrite),
        .iMemWriteData (iMemWriteData),
        .oMemReadData  (oMemReadData),
        .oInterrupt    (oInterrupt),
        .oLed          (oLed),
        .iSwitch       (iSwitch),
        .oDigit        (oDigit)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] m_th, m_tl, m_systick;
    logic [2:0]  m_tcon;
    logic [7:0]  m_led;
    logic [11:0] m_digi;
    logic [7:0]  sw_hist[$];
    bit          m_valid = 0;

    // Last sampled values, for directed checks
    logic [31:0] last_rd;
    logic        last_irq;
    logic [7:0]  last_led;
    logic [11:0] last_digi;
    logic [7:0]  sw_cur = 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Switch value seen by the bus: the one sampled two non-reset edges ago
    function automatic logic [7:0] m_switch();
        if (sw_hist.size() >= 2) return sw_hist[sw_hist.size() - 2];
        return 8'h00;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [7:0] off;
        if (a[31:8] != 24'h400000) return 32'h0;
        off = a[7:0] & 8'hFC;
        case (off)
            8'h00: return m_th;
            8'h04: return m_tl;
            8'h08: return {29'h0, m_tcon};
            8'h0C: return {24'h0, m_led};
            8'h10: return {24'h0, m_switch()};
            8'h14: return {20'h0, m_digi};
`ifdef PERIPH_SYSTICK_EN
            8'h18: return m_systick;
`endif
            default: return 32'h0;
        endcase
    endfunction

    // Advance the model across one rising edge
    task automatic m_step(input bit rst_n, input logic [31:0] a, input bit wr,
                          input logic [31:0] wd, input logic [7:0] sw);
        bit          hit, reload, irq_set;
        logic [7:0]  off;
        logic [31:0] n_tl;
        logic [2:0]  n_tcon;
        if (!rst_n) begin
            m_th = 0; m_tl = 0; m_tcon = 0; m_led = 0; m_digi = 0; m_systick = 0;
            sw_hist.delete();
            return;
        end
        hit     = (a[31:8] == 24'h400000);
        off     = a[7:0] & 8'hFC;
        reload  = m_tcon[0] && (m_tl == 32'hFFFFFFFF);
        irq_set = reload && m_tcon[1];
        n_tl    = !m_tcon[0] ? m_tl : (reload ? m_th : m_tl + 32'd1);
        n_tcon  = m_tcon;
        if (irq_set) n_tcon[2] = 1'b1;
        if (hit && wr) begin
            case (off)
                8'h00: m_th = wd;
                8'h04: n_tl = wd;
                8'h08: n_tcon = {wd[2] | irq_set, wd[1:0]};
                8'h0C: m_led = wd[7:0];
                8'h14: m_digi = wd[11:0];
                default: ;
            endcase
        end
        m_tl = n_tl;
        m_tcon = n_tcon;
        m_systick = m_systick + 32'd1;
        sw_hist.push_back(sw);
        if (sw_hist.size() > 4) void'(sw_hist.pop_front());
    endtask

    // One bus cycle: drive, check outputs against the model, then advance the model
    task automatic cyc(input bit rst_n, input logic [31:0] a, input bit rd, input bit wr,
                       input logic [31:0] wd, input logic [7:0] sw);
        @(negedge clk);
        reset = rst_n; iMemAddr = a; iMemRead = rd; iMemWrite = wr;
        iMemWriteData = wd; iSwitch = sw;
        #1;
        last_rd = oMemReadData; last_irq = oInterrupt; last_led = oLed; last_digi = oDigit;
        if (m_valid) begin
            chk("rdata", oMemReadData, rd ? m_read(a) : 32'h0);
            chk("irq",   {31'h0, oInterrupt}, {31'h0, m_tcon[2]});
            chk("led",   {24'h0, oLed}, {24'h0, m_led});
            chk("digit", {20'h0, oDigit}, {20'h0, m_digi});
        end
        m_step(rst_n, a, wr, wd, sw);
        if (!rst_n) m_valid = 1;
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        cyc(1'b1, a, 1'b0, 1'b1, d, sw_cur);
    endtask

    task automatic bus_rd(input logic [31:0] a);
        cyc(1'b1, a, 1'b1, 1'b0, 32'h0, sw_cur);
    endtask

    task automatic idle();
        cyc(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, sw_cur);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, wd;
        int          pick;
        bit          rst_n, rd, wr;

        reset = 1'b0; iMemAddr = 0; iMemRead = 0; iMemWrite = 0; iMemWriteData = 0; iSwitch = 0;
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, sw_cur);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, sw_cur);

        // Timer reload with interrupt
        bus_wr(32'h40000000, 32'hFFFFFFF0);
        bus_wr(32'h40000004, 32'hFFFFFFFE);
        bus_wr(32'h40000008, 32'h3);
        bus_rd(32'h40000004); chk("t_tl_fe", last_rd, 32'hFFFFFFFE);
        bus_rd(32'h40000004); chk("t_tl_ff", last_rd, 32'hFFFFFFFF);
        chk("t_irq_pre", {31'h0, last_irq}, 32'h0);
        bus_rd(32'h40000008); chk("t_tcon7", last_rd, 32'h7);
        chk("t_irq_post", {31'h0, last_irq}, 32'h1);
        bus_rd(32'h40000004); chk("t_tl_reload", last_rd, 32'hFFFFFFF1);

        // Clear attempt in the reload cycle loses to the set
        bus_wr(32'h40000004, 32'hFFFFFFFF);
        bus_wr(32'h40000008, 32'h3);
        bus_rd(32'h40000008); chk("t_tcon_setwins", last_rd, 32'h7);
        chk("t_irq_held", {31'h0, last_irq}, 32'h1);
        bus_wr(32'h40000008, 32'h3);
        bus_rd(32'h40000008); chk("t_tcon_clr", last_rd, 32'h3);
        chk("t_irq_clr", {31'h0, last_irq}, 32'h0);

        // LED and seven-segment
        bus_wr(32'h4000000C, 32'hA5);
        bus_wr(32'h40000014, 32'h3F1);
        bus_rd(32'h4000000C); chk("led_rd", last_rd, 32'h000000A5);
        chk("led_out", {24'h0, last_led}, 32'hA5);
        chk("digi_out", {20'h0, last_digi}, 32'h3F1);

        // Switch synchronizer latency
        sw_cur = 8'h00; idle(); idle(); idle();
        sw_cur = 8'h5A;
        bus_rd(32'h40000010); chk("sw_c1", last_rd, 32'h0);
        bus_rd(32'h40000010); chk("sw_c2", last_rd, 32'h0);
        bus_rd(32'h40000010); chk("sw_c3", last_rd, 32'h5A);

        // Reset while the timer runs, with a colliding LED write
        cyc(1'b0, 32'h4000000C, 1'b0, 1'b1, 32'hFF, sw_cur);
        bus_rd(32'h40000004); chk("rst_tl", last_rd, 32'h0);
        chk("rst_irq", {31'h0, last_irq}, 32'h0);
        chk("rst_led", {24'h0, last_led}, 32'h0);
        chk("rst_digi", {20'h0, last_digi}, 32'h0);
        bus_rd(32'h40000008); chk("rst_tcon", last_rd, 32'h0);
        bus_rd(32'h40000020); chk("unmapped", last_rd, 32'h0);
        bus_rd(32'h50000000); chk("miss", last_rd, 32'h0);

        // Ignored writes: miss page, read-only and unmapped offsets
        bus_wr(32'h40000100, 32'h12345678);
        bus_rd(32'h40000000); chk("miss_wr_th", last_rd, 32'h0);
        bus_wr(32'h40000010, 32'hFFFFFFFF);
        bus_rd(32'h40000010); chk("ro_switch", last_rd, 32'h5A);
        bus_wr(32'h4000001C, 32'hFFFFFFFF);
        bus_rd(32'h4000001C); chk("unmapped_wr", last_rd, 32'h0);

        // SYSTICK count after reset
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, sw_cur);
        for (int i = 0; i < 100; i++) idle();
        bus_rd(32'h40000018);
`ifdef PERIPH_SYSTICK_EN
        chk("systick100", last_rd, 32'd100);
`else
        chk("systick_absent", last_rd, 32'd0);
`endif

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            pick = int'($urandom_range(0, 9));
            if (pick <= 7)
                a = 32'h40000000 + 32'(pick * 4) + 32'($urandom_range(0, 3));
            else if (pick == 8)
                a = 32'h40000000 + 32'($urandom_range(8, 63) * 4);
            else begin
                a = $urandom;
                if (a[31:8] == 24'h400000) a[31] = 1'b1;
            end
            wd = $urandom;
            if (pick == 0 && $urandom_range(0, 1) == 1) wd = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
            if (pick == 1 && $urandom_range(0, 1) == 1) wd = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
            if (pick == 2) wd = 32'($urandom_range(0, 7)) | (($urandom_range(0, 3) != 0) ? 32'h1 : 32'h0);
            rd    = ($urandom_range(0, 1) == 1);
            wr    = ($urandom_range(0, 2) == 0);
            rst_n = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 7) == 0) sw_cur = 8'($urandom);
            cyc(rst_n, a, rd, wr, wd, sw_cur);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
